// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// requester limits and APB constants.
package uart_sched_pkg;

    localparam int          NUM_REQ_MAX       = 8;
    localparam logic [31:0] FULL_STRB         = 32'hFFFF_FFFF;
    localparam logic [31:0] DEFAULT_UART_ADDR = 32'h0000_0000;

    // Scheduler FSM encoding (plain constants so older tools can consume them)
    typedef logic [2:0] sched_state_t;

    localparam sched_state_t ST_IDLE      = 3'd0;
    localparam sched_state_t ST_SETUP     = 3'd1;
    localparam sched_state_t ST_ACCESS    = 3'd2;
    localparam sched_state_t ST_WAIT_DONE = 3'd3;
    localparam sched_state_t ST_COMPLETE  = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// last_grant+1 (mod NUM_REQ).
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last_grant,
    output logic               valid,
    output logic [2:0]         grant
);

    localparam logic [2:0] LAST_IDX  = 3'(NUM_REQ - 1);
    localparam logic [3:0] NUM_REQ_W = 4'(NUM_REQ);

    logic [2:0]           start;
    logic [2*NUM_REQ-1:0] req_twice;
    logic [NUM_REQ-1:0]   window;
    logic [NUM_REQ:0]     seen;
    logic [2:0]           offset_chain [NUM_REQ+1];
    logic [3:0]           sum;

    // Rotate the request vector so the highest-priority requester sits at bit 0
    assign start     = (last_grant >= LAST_IDX) ? 3'd0 : last_grant + 3'd1;
    assign req_twice = {req, req};
    assign window    = NUM_REQ'(req_twice >> start);

    // Priority-encode the rotated window: lowest set bit wins
    assign seen[0]         = 1'b0;
    assign offset_chain[0] = 3'd0;
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_prio
        assign seen[gi+1]         = seen[gi] | window[gi];
        assign offset_chain[gi+1] = offset_chain[gi] |
                                    ((window[gi] && !seen[gi]) ? 3'(gi) : 3'd0);
    end

    // Undo the rotation to recover the absolute requester index
    assign valid = seen[NUM_REQ];
    assign sum   = {1'b0, start} + {1'b0, offset_chain[NUM_REQ]};
    assign grant = (sum >= NUM_REQ_W) ? 3'(sum - NUM_REQ_W) : sum[2:0];

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: round-robin arbitrates NUM_REQ word senders and
// performs one APB write per word toward the UART transmitter, then waits for
// tx_done before acknowledging the requester.
// Optional feature: define UART_TX_SCHED_TIMEOUT_EN to add a transfer timeout
// (ACCESS + WAIT_DONE limited to TIMEOUT_CYCLES) with a timeout_err pulse.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter logic [31:0] UART_ADDR      = DEFAULT_UART_ADDR,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [31:0]            padd,
    output logic [31:0]            pwdata_tx,
    output logic [31:0]            pstrb,
    input  logic                   pready,
    input  logic                   tx_done,
`ifdef UART_TX_SCHED_TIMEOUT_EN
    output logic                   timeout_err,
`endif
    output logic                   busy,
    output logic [2:0]             grant_id
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);

    sched_state_t state_reg;
    sched_state_t state_next;
    logic [2:0]   last_grant_reg;
    logic         arb_valid;
    logic [2:0]   arb_grant;
    logic [31:0]  req_word [NUM_REQ_MAX];
    logic         in_apb;
    logic         tmo_at_limit;
    logic         tmo_fire;

    // Unpack requester words; unused slots read as zero so a 3-bit index is exact
    for (genvar gi = 0; gi < NUM_REQ_MAX; gi++) begin : g_word
        if (gi < NUM_REQ) begin : g_used
            assign req_word[gi] = req_data[32*gi +: 32];
        end else begin : g_pad
            assign req_word[gi] = 32'h0;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_reg),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    // APB and status outputs decoded straight from the state so reset clears them at once
    assign in_apb  = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
    assign psel    = in_apb;
    assign penable = (state_reg == ST_ACCESS);
    assign pwrite  = in_apb;
    assign padd    = in_apb ? UART_ADDR : 32'h0;
    assign pstrb   = in_apb ? FULL_STRB : 32'h0;
    assign busy    = (state_reg != ST_IDLE);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
        assign ack[gi] = (state_reg == ST_COMPLETE) && (grant_id == 3'(gi));
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_reg;

    assign tmo_at_limit = (tmo_cnt_reg == CNT_LAST);

    // Count cycles spent waiting on the UART; cleared whenever no transfer is waiting
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_fire;
            if ((state_reg == ST_ACCESS) || (state_reg == ST_WAIT_DONE)) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end else begin
                tmo_cnt_reg <= '0;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign tmo_at_limit       = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Next-state logic; forward progress takes precedence over an expiring timeout
    always_comb begin
        state_next = state_reg;
        tmo_fire   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (arb_valid) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    state_next = ST_WAIT_DONE;
                end else if (tmo_at_limit) begin
                    state_next = ST_IDLE;
                    tmo_fire   = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_next = ST_COMPLETE;
                end else if (tmo_at_limit) begin
                    state_next = ST_IDLE;
                    tmo_fire   = 1'b1;
                end
            end
            ST_COMPLETE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register, grant/data capture at arbitration, round-robin pointer update
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            grant_id       <= 3'd0;
            pwdata_tx      <= 32'h0;
            last_grant_reg <= LAST_IDX;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && arb_valid) begin
                grant_id  <= arb_grant;
                pwdata_tx <= req_word[arb_grant];
            end
            if ((state_reg == ST_COMPLETE) || tmo_fire) begin
                last_grant_reg <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler. Directed scenarios followed by
// randomized transactions checked against a transaction-level round-robin model.
// Build with UART_TX_SCHED_TIMEOUT_EN defined to also exercise the timeout path.
module tb_uart_tx_scheduler;

    localparam int          N    = 4;
    localparam logic [31:0] ADDR = 32'h4000_1000;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int          TMO  = 16;
`else
    localparam int          TMO  = 256;
`endif

    logic            pclk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [31:0]     words [N];
    logic [32*N-1:0] req_data;
    logic [N-1:0]    ack;
    logic            psel, penable, pwrite;
    logic [31:0]     padd, pwdata_tx, pstrb;
    logic            pready = 1'b0;
    logic            tx_done = 1'b0;
    logic            busy;
    logic [2:0]      grant_id;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic            timeout_err;
`endif

    int tests = 0;
    int fails = 0;
    int model_last = N - 1;
    int seen_grant = 0;
    int ack_pulses = 0;
    int access_cycles = 0;

    assign req_data = {words[3], words[2], words[1], words[0]};

    uart_tx_scheduler #(
        .NUM_REQ        (N),
        .UART_ADDR      (ADDR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .padd        (padd),
        .pwdata_tx   (pwdata_tx),
        .pstrb       (pstrb),
        .pready      (pready),
        .tx_done     (tx_done),
`ifdef UART_TX_SCHED_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 pclk = ~pclk;

    // Activity counters sampled at the active edge (pre-update values)
    always @(posedge pclk) begin
        if (ack != '0) ack_pulses <= ack_pulses + 1;
        if (psel && penable) access_cycles <= access_cycles + 1;
    end

    // Round-robin reference: scan from last+1 around the ring
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int off = 1; off <= N; off++) begin
            int i;
            i = (last + off) % N;
            if (((r >> i) & 4'd1) != 4'd0) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_psel"},      32'(psel),     32'd0);
        chk({tag, "_penable"},   32'(penable),  32'd0);
        chk({tag, "_pwrite"},    32'(pwrite),   32'd0);
        chk({tag, "_padd"},      padd,          32'd0);
        chk({tag, "_pwdata"},    pwdata_tx,     32'd0);
        chk({tag, "_pstrb"},     pstrb,         32'd0);
        chk({tag, "_ack"},       32'(ack),      32'd0);
        chk({tag, "_busy"},      32'(busy),     32'd0);
        chk({tag, "_grant"},     32'(grant_id), 32'd0);
`ifdef UART_TX_SCHED_TIMEOUT_EN
        chk({tag, "_tmo_err"},   32'(timeout_err), 32'd0);
`endif
    endtask

    // One transaction, entered at a negedge with the DUT idle and req already driven
    task automatic do_txn(input int pw, input int dw, input bit hold, input bit drop,
                          input int abort_at, input bit scramble);
        int          id;
        logic [1:0]  idx;
        logic [31:0] dat;
        id  = rr_pick(req, model_last);
        idx = id[1:0];
        dat = words[idx];
        @(negedge pclk);
        chk("setup_busy",    32'(busy),     32'd1);
        chk("setup_psel",    32'(psel),     32'd1);
        chk("setup_penable", 32'(penable),  32'd0);
        chk("setup_pwrite",  32'(pwrite),   32'd1);
        chk("setup_padd",    padd,          ADDR);
        chk("setup_pstrb",   pstrb,         32'hFFFF_FFFF);
        chk("setup_grant",   32'(grant_id), 32'(id));
        chk("setup_pwdata",  pwdata_tx,     dat);
        chk("setup_ack",     32'(ack),      32'd0);
        seen_grant = int'(grant_id);
        if (scramble) begin
            words = '{$urandom, $urandom, $urandom, $urandom};
            req   = req | 4'($urandom_range(0, 15));
        end
        for (int k = 0; k <= pw; k++) begin
            @(negedge pclk);
            chk("access_psel",    32'(psel),    32'd1);
            chk("access_penable", 32'(penable), 32'd1);
            chk("access_pwdata",  pwdata_tx,    dat);
            chk("access_ack",     32'(ack),     32'd0);
            pready = (k == pw);
        end
        for (int k = 0; k <= dw; k++) begin
            @(negedge pclk);
            pready = 1'b0;
            chk("wait_psel",    32'(psel),     32'd0);
            chk("wait_penable", 32'(penable),  32'd0);
            chk("wait_busy",    32'(busy),     32'd1);
            chk("wait_ack",     32'(ack),      32'd0);
            chk("wait_pwdata",  pwdata_tx,     dat);
            chk("wait_grant",   32'(grant_id), 32'(id));
            if (drop && k == 0) req[idx] = 1'b0;
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge pclk);
                rst_n      = 1'b1;
                req        = '0;
                tx_done    = 1'b0;
                model_last = N - 1;
                return;
            end
            tx_done = (k == dw);
        end
        @(negedge pclk);
        tx_done = 1'b0;
        chk("complete_ack",  32'(ack),  32'(1 << id));
        chk("complete_busy", 32'(busy), 32'd1);
        chk("complete_psel", 32'(psel), 32'd0);
        model_last = id;
        if (!hold) req[idx] = 1'b0;
        @(negedge pclk);
        chk("idle_busy",  32'(busy),     32'd0);
        chk("idle_ack",   32'(ack),      32'd0);
        chk("idle_grant", 32'(grant_id), 32'(id));
`ifdef UART_TX_SCHED_TIMEOUT_EN
        chk("idle_tmo_err", 32'(timeout_err), 32'd0);
`endif
        $display("[TB] txn grant=%0d data=%08h pready_wait=%0d done_wait=%0d", id, dat, pw, dw);
    endtask

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // A transfer whose tx_done never comes; only a single requester is active
    task automatic do_timeout();
        int         id;
        logic [1:0] idx;
        id  = rr_pick(req, model_last);
        idx = id[1:0];
        @(negedge pclk);
        chk("tmo_setup_grant", 32'(grant_id), 32'(id));
        @(negedge pclk);
        chk("tmo_access_penable", 32'(penable), 32'd1);
        pready = 1'b1;
        for (int k = 1; k < TMO; k++) begin
            @(negedge pclk);
            pready = 1'b0;
            chk("tmo_wait_busy", 32'(busy),        32'd1);
            chk("tmo_wait_err",  32'(timeout_err), 32'd0);
            chk("tmo_wait_ack",  32'(ack),         32'd0);
        end
        @(negedge pclk);
        chk("tmo_idle_busy", 32'(busy),        32'd0);
        chk("tmo_pulse",     32'(timeout_err), 32'd1);
        chk("tmo_no_ack",    32'(ack),         32'd0);
        model_last = id;
        req[idx]   = 1'b0;
        @(negedge pclk);
        chk("tmo_pulse_end", 32'(timeout_err), 32'd0);
        seen_grant = id;
        $display("[TB] timeout grant=%0d", id);
    endtask
`endif

    initial begin
        int acks0;
        int acc0;
        int tid;
        words = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

        // Reset: requests pending must not be granted while rst_n is low
        req = 4'b1111;
        repeat (2) @(negedge pclk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Fairness with all four requests held
        for (int k = 0; k < 5; k++) begin
            do_txn(k % 2, 1, 1'b1, 1'b0, -1, 1'b0);
            chk("fair_order", 32'(seen_grant), 32'(k % 4));
        end
        req = '0;
        @(negedge pclk);

        // Single request
        words[0] = 32'hA5A5_0001;
        req      = 4'b0001;
        acks0    = ack_pulses;
        do_txn(0, 9, 1'b0, 1'b0, -1, 1'b0);
        chk("single_ack_count", 32'(ack_pulses - acks0), 32'd1);

        // pready stalled five cycles, data source changing underneath
        words[1] = 32'hC0DE_0101;
        req      = 4'b0010;
        acc0     = access_cycles;
        do_txn(5, 2, 1'b0, 1'b0, -1, 1'b1);
        chk("stall_access_cycles", 32'(access_cycles - acc0), 32'd6);
        req = '0;
        @(negedge pclk);

        // req[2] withdrawn while waiting for tx_done
        req   = 4'b0100;
        acks0 = ack_pulses;
        do_txn(1, 4, 1'b0, 1'b1, -1, 1'b0);
        chk("drop_ack_count", 32'(ack_pulses - acks0), 32'd1);

        // Reset during WAIT_DONE, then pointer back to requester 0
        req   = 4'b1000;
        acks0 = ack_pulses;
        do_txn(0, 6, 1'b0, 1'b0, 2, 1'b0);
        chk("abort_no_ack", 32'(ack_pulses - acks0), 32'd0);
        req = 4'b1111;
        do_txn(0, 1, 1'b0, 1'b0, -1, 1'b0);
        chk("post_reset_grant", 32'(seen_grant), 32'd0);
        req = '0;
        @(negedge pclk);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        req   = 4'b0010;
        acks0 = ack_pulses;
        do_timeout();
        tid = seen_grant;
        chk("tmo_ack_count", 32'(ack_pulses - acks0), 32'd0);
        req = 4'b1111;
        do_txn(0, 1, 1'b0, 1'b0, -1, 1'b0);
        chk("tmo_next_grant", 32'(seen_grant), 32'((tid + 1) % N));
        req = '0;
        @(negedge pclk);
`else
        tid = 0;
`endif

        // Randomized traffic against the round-robin model
        for (int n = 0; n < 24; n++) begin
            if (req == '0) req = 4'($urandom_range(1, 15));
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b0,
                   1'($urandom_range(0, 1)), -1, 1'b1);
        end

        req = '0;
        @(negedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
